// File: rtl/output_safety_sequencer.sv
// Output-unit sequencer: drives redundant relay and dynamic switch controls,
// runs a power-on self-test with readback, and latches the safe state on faults.
module output_safety_sequencer #(
  parameter int unsigned TOGGLE_HALF    = 8,
  parameter int unsigned TEST_CYCLES    = 16,
  parameter int unsigned MISMATCH_LIMIT = 3,
  parameter int unsigned FB_TIMEOUT     = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cmpValid,
  input  logic       cmpMatch,
  input  logic       fbRelay,
  input  logic       fbSwitchOpen,
  input  logic       clearFault,
  output logic       relayCtrl1,
  output logic       relayCtrl2,
  output logic       switchCtrl1,
  output logic       switchCtrl2,
  output logic [1:0] state,
  output logic [1:0] faultCode,
  output logic [7:0] mismatchCnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELFTEST = 2'd1,
    RUN      = 2'd2,
    FAULT    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_SELFTEST = 2'd1,
    FC_MISMATCH = 2'd2,
    FC_READBACK = 2'd3
  } fault_t;

  localparam logic [7:0] TEST_LAST  = 8'(TEST_CYCLES - 1);
  localparam logic [7:0] HALF_LAST  = 8'(TOGGLE_HALF - 1);
  localparam logic [7:0] MM_LIMIT   = 8'(MISMATCH_LIMIT);
  localparam logic [7:0] FB_LIMIT   = 8'(FB_TIMEOUT);

  state_t     state_q;
  logic [7:0] test_cnt;
  logic [7:0] toggle_cnt;
  logic [7:0] fb_cnt;

  logic [7:0] mm_next;
  logic [7:0] fb_next;
  logic       mm_strobe;
  logic       mm_hit;
  logic       fb_bad;
  logic       fb_hit;
  logic       readback_safe;

  assign state = state_q;

  // RUN-time fault detection: both counters saturate so they never wrap to 0.
  always_comb begin
    mm_next       = (mismatchCnt == 8'hFF) ? 8'hFF : mismatchCnt + 8'd1;
    fb_next       = (fb_cnt == 8'hFF) ? 8'hFF : fb_cnt + 8'd1;
    mm_strobe     = cmpValid & ~cmpMatch;
    mm_hit        = mm_strobe & (mm_next == MM_LIMIT);
    fb_bad        = ~fbRelay | fbSwitchOpen;
    fb_hit        = fb_bad & (fb_next == FB_LIMIT);
    readback_safe = ~fbRelay & fbSwitchOpen;
  end

  // Outputs are computed from the next state so they change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      relayCtrl1  <= 1'b0;
      relayCtrl2  <= 1'b0;
      switchCtrl1 <= 1'b0;
      switchCtrl2 <= 1'b0;
      faultCode   <= FC_NONE;
      mismatchCnt <= 8'd0;
      test_cnt    <= 8'd0;
      toggle_cnt  <= 8'd0;
      fb_cnt      <= 8'd0;
    end else begin
      relayCtrl2 <= 1'b0;
      case (state_q)
        IDLE: begin
          relayCtrl1  <= 1'b0;
          switchCtrl1 <= 1'b0;
          switchCtrl2 <= 1'b0;
          if (start) begin
            state_q     <= SELFTEST;
            test_cnt    <= 8'd0;
            mismatchCnt <= 8'd0;
            fb_cnt      <= 8'd0;
          end
        end

        SELFTEST: begin
          relayCtrl1  <= 1'b0;
          switchCtrl1 <= 1'b0;
          switchCtrl2 <= 1'b0;
          if (test_cnt == TEST_LAST) begin
            test_cnt <= 8'd0;
            if (readback_safe) begin
              state_q     <= RUN;
              relayCtrl1  <= 1'b1;
              switchCtrl1 <= 1'b1;
              switchCtrl2 <= 1'b0;
              toggle_cnt  <= 8'd0;
              fb_cnt      <= 8'd0;
            end else begin
              state_q   <= FAULT;
              faultCode <= FC_SELFTEST;
            end
          end else begin
            test_cnt <= test_cnt + 8'd1;
          end
        end

        RUN: begin
          if (cmpValid) begin
            mismatchCnt <= cmpMatch ? 8'd0 : mm_next;
          end
          fb_cnt <= fb_bad ? fb_next : 8'd0;

          // Mismatch takes priority when both faults land in the same cycle.
          if (mm_hit || fb_hit) begin
            state_q     <= FAULT;
            faultCode   <= mm_hit ? FC_MISMATCH : FC_READBACK;
            relayCtrl1  <= 1'b0;
            switchCtrl1 <= 1'b0;
            switchCtrl2 <= 1'b0;
            toggle_cnt  <= 8'd0;
          end else begin
            relayCtrl1 <= 1'b1;
            if (toggle_cnt == HALF_LAST) begin
              toggle_cnt  <= 8'd0;
              switchCtrl1 <= ~switchCtrl1;
              switchCtrl2 <= switchCtrl1;
            end else begin
              toggle_cnt <= toggle_cnt + 8'd1;
            end
          end
        end

        FAULT: begin
          relayCtrl1  <= 1'b0;
          switchCtrl1 <= 1'b0;
          switchCtrl2 <= 1'b0;
          if (clearFault) begin
            state_q     <= IDLE;
            faultCode   <= FC_NONE;
            mismatchCnt <= 8'd0;
            fb_cnt      <= 8'd0;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_safety_sequencer.sv
// Directed bench for output_safety_sequencer: expected output snapshots are
// queued when each step is driven and compared one cycle later.
module tb_output_safety_sequencer;

  localparam int HALF = 8;

  logic       clk;
  logic       rst;
  logic       start;
  logic       cmpValid;
  logic       cmpMatch;
  logic       fbRelay;
  logic       fbSwitchOpen;
  logic       clearFault;
  logic       relayCtrl1;
  logic       relayCtrl2;
  logic       switchCtrl1;
  logic       switchCtrl2;
  logic [1:0] state;
  logic [1:0] faultCode;
  logic [7:0] mismatchCnt;

  logic [15:0] exp_q[$];
  string       tag_q[$];
  int          checks;
  int          errors;
  int          run_k;

  output_safety_sequencer #(
    .TOGGLE_HALF   (HALF),
    .TEST_CYCLES   (16),
    .MISMATCH_LIMIT(3),
    .FB_TIMEOUT    (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cmpValid    (cmpValid),
    .cmpMatch    (cmpMatch),
    .fbRelay     (fbRelay),
    .fbSwitchOpen(fbSwitchOpen),
    .clearFault  (clearFault),
    .relayCtrl1  (relayCtrl1),
    .relayCtrl2  (relayCtrl2),
    .switchCtrl1 (switchCtrl1),
    .switchCtrl2 (switchCtrl2),
    .state       (state),
    .faultCode   (faultCode),
    .mismatchCnt (mismatchCnt)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Snapshot layout: {state, faultCode, mismatchCnt, relay1, relay2, sw1, sw2}
  function automatic logic [15:0] pk(input logic [1:0] st, input logic [1:0] fc,
                                     input logic [7:0] mc, input logic r1, input logic r2,
                                     input logic s1, input logic s2);
    return {st, fc, mc, r1, r2, s1, s2};
  endfunction

  function automatic logic [15:0] act(input logic [7:0] mc, input int k);
    logic sw;
    sw = ((k / HALF) % 2) == 0;
    return pk(2'd2, 2'd0, mc, 1'b1, 1'b0, sw, ~sw);
  endfunction

  function automatic logic [15:0] safe(input logic [1:0] st, input logic [1:0] fc,
                                       input logic [7:0] mc);
    return pk(st, fc, mc, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Scoreboard
  task automatic compare_out();
    logic [15:0] got;
    logic [15:0] e;
    string       t;
    got = {state, faultCode, mismatchCnt, relayCtrl1, relayCtrl2, switchCtrl1, switchCtrl2};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s: observed=%h required=%h", t, got, e);
    end
  endtask

  task automatic check_now(input logic [15:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    compare_out();
  endtask

  // Driver: apply inputs at negedge, queue expectation, compare after the edge
  task automatic step(input logic s, input logic v, input logic m, input logic fr,
                      input logic fs, input logic c, input logic [15:0] e, input string tag);
    @(negedge clk);
    start        = s;
    cmpValid     = v;
    cmpMatch     = m;
    fbRelay      = fr;
    fbSwitchOpen = fs;
    clearFault   = c;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  // Start pulse plus the 16 self-test observations; caller drives the decision edge.
  task automatic selftest_window(input logic fr, input logic fs, input string tag);
    step(1'b1, 1'b0, 1'b0, fr, fs, 1'b0, safe(2'd1, 2'd0, 8'd0), tag);
    repeat (15) step(1'b0, 1'b0, 1'b0, fr, fs, 1'b0, safe(2'd1, 2'd0, 8'd0), tag);
  endtask

  initial begin
    logic       pat_match[5];
    logic [7:0] pat_mc[5];
    pat_match = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    pat_mc    = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
    checks = 0;
    errors = 0;
    run_k  = 0;
    rst = 1'b1; start = 1'b0; cmpValid = 1'b0; cmpMatch = 1'b0;
    fbRelay = 1'b0; fbSwitchOpen = 1'b0; clearFault = 1'b0;
    #1;
    check_now(safe(2'd0, 2'd0, 8'd0), "reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, safe(2'd0, 2'd0, 8'd0), "idle_ignores_inputs");

    // Self-test pass, then waveform and mismatch counting
    selftest_window(1'b0, 1'b1, "selftest_state");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, act(8'd0, 0), "run_entry");
    run_k = 0;
    repeat (20) begin
      run_k++;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, act(8'd0, run_k), "toggle");
    end
    for (int i = 0; i < 5; i++) begin
      run_k++;
      step(1'b0, 1'b1, pat_match[i], 1'b1, 1'b0, 1'b0, act(pat_mc[i], run_k), "mismatch_seq");
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, safe(2'd3, 2'd2, 8'd3), "mismatch_fault");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, safe(2'd3, 2'd2, 8'd3), "fault_ignores_start");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, safe(2'd3, 2'd2, 8'd3), "fault_latched");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, safe(2'd0, 2'd0, 8'd0), "clear_with_start");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, safe(2'd0, 2'd0, 8'd0), "idle_after_clear");

    // Self-test failure with relay readback stuck closed
    selftest_window(1'b1, 1'b1, "selftest_stuck");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, safe(2'd3, 2'd1, 8'd0), "selftest_fail");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, safe(2'd3, 2'd1, 8'd0), "selftest_fail_start");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, safe(2'd0, 2'd0, 8'd0), "selftest_fail_clear");

    // Readback timeout window: 31 bad cycles tolerated, 32 fault
    selftest_window(1'b0, 1'b1, "selftest_state2");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, act(8'd0, 0), "run_entry2");
    run_k = 0;
    repeat (31) begin
      run_k++;
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, act(8'd0, run_k), "fb_31_bad");
    end
    run_k++;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, act(8'd0, run_k), "fb_good_clears");
    repeat (31) begin
      run_k++;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, act(8'd0, run_k), "fb_relay_open");
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, safe(2'd3, 2'd3, 8'd0), "fb_timeout");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, safe(2'd0, 2'd0, 8'd0), "fb_timeout_clear");

    // Mismatch and readback fault in the same cycle
    selftest_window(1'b0, 1'b1, "selftest_state3");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, act(8'd0, 0), "run_entry3");
    for (int k = 1; k <= 31; k++) begin
      step(1'b0, k >= 30, 1'b0, 1'b1, 1'b1, 1'b0,
           act((k >= 30) ? 8'(k - 29) : 8'd0, k), "simul_pre");
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, safe(2'd3, 2'd2, 8'd3), "simul_fault");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, safe(2'd0, 2'd0, 8'd0), "simul_clear");

    // Asynchronous reset mid-RUN
    selftest_window(1'b0, 1'b1, "selftest_state4");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, act(8'd0, 0), "run_entry4");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, act(8'd1, 1), "pre_reset_mismatch");
    @(negedge clk);
    cmpValid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_now(safe(2'd0, 2'd0, 8'd0), "async_reset");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, safe(2'd0, 2'd0, 8'd0), "post_reset_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_safety_sequencer.md
# output_safety_sequencer

Controller that sequences the comparator's output unit. It generates the two redundant relay-control lines and the two dynamic switch-control lines that feed the output unit, and runs a power-on self-test with relay and switch readback. In operation it supervises the comparison results and forces the output board into its safe state, latched, on persistent channel disagreement or readback failure. It sits between the bus-comparison core and the output unit.

## Interface
Parameters:
- TOGGLE_HALF, 8, clocks per half-period of the switch-control square wave (range 2..255)
- TEST_CYCLES, 16, self-test duration in clocks (range 1..255)
- MISMATCH_LIMIT, 3, consecutive mismatching comparisons that trigger a fault (range 1..255)
- FB_TIMEOUT, 32, consecutive clocks of bad readback in RUN that trigger a fault (range 1..255)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  arm request; one-cycle pulse, honoured only in IDLE
- cmpValid  in  1  one-cycle strobe: a comparison result is present
- cmpMatch  in  1  1 = both channels agreed; qualified by cmpValid
- fbRelay  in  1  readback of relay enable; 1 = relay closed
- fbSwitchOpen  in  1  readback of output-board power switch; 1 = switch open (safe)
- clearFault  in  1  fault acknowledge; honoured only in FAULT
- relayCtrl1  out  1  relay control, channel 1
- relayCtrl2  out  1  relay control, channel 2
- switchCtrl1  out  1  dynamic switch control, channel 1
- switchCtrl2  out  1  dynamic switch control, channel 2
- state  out  2  IDLE=0, SELFTEST=1, RUN=2, FAULT=3
- faultCode  out  2  0 = none, 1 = self-test fail, 2 = mismatch, 3 = readback timeout
- mismatchCnt  out  8  current consecutive-mismatch count

## Operation
- Safe pattern: relayCtrl1 = relayCtrl2 = 0, so the relay XOR is 0. switchCtrl1 = switchCtrl2 = 0, held static with no toggling.
- Active pattern: relayCtrl1 = 1 and relayCtrl2 = 0, so the XOR is 1. switchCtrl1 is a square wave and switchCtrl2 = ~switchCtrl1 at all times.
- IDLE: safe pattern. start=1 → SELFTEST. All other inputs are ignored.
- SELFTEST: safe pattern for exactly TEST_CYCLES clocks.
  - On the last cycle, sample the readback. If fbRelay=0 and fbSwitchOpen=1 → RUN.
  - Otherwise → FAULT with faultCode=1.
- RUN: active pattern.
  - cmpValid & ~cmpMatch: mismatchCnt increments, saturating at 255.
  - cmpValid & cmpMatch: mismatchCnt clears to 0.
  - When the incremented value equals MISMATCH_LIMIT → FAULT with faultCode=2.
  - Bad readback (fbRelay=0 or fbSwitchOpen=1) increments the readback counter; good readback clears it. When the counter reaches FB_TIMEOUT → FAULT with faultCode=3. This window also covers relay pull-in latency after RUN entry.
  - start is ignored.
- FAULT: safe pattern, latched. faultCode holds its value.
  - clearFault=1 → IDLE, and clears faultCode, mismatchCnt and the readback counter.
  - start is ignored.
- Simultaneous mismatch and readback faults in the same cycle: faultCode=2.
- Only the first fault is recorded; faultCode does not change while in FAULT.
- mismatchCnt clears on SELFTEST entry and holds its value in FAULT until clearFault.

## Timing
- Reset values: state=IDLE, all control outputs 0, faultCode=0, mismatchCnt=0, all internal counters 0.
- Asserting rst mid-RUN forces the safe pattern immediately, without waiting for a clock edge.
- All outputs are registered and derived from the next state, so the output pattern changes on the same edge as state.
  - Detection cycle N (input sampled at edge N) → state and outputs updated at edge N, with no extra cycle.
  - FAULT entry drops relayCtrl1 and both switchCtrl lines to 0 on that edge.
- start sampled at edge N in IDLE → state=SELFTEST after edge N. RUN is entered after edge N+TEST_CYCLES on a pass.
- Switch waveform:
  - On the RUN-entry edge: switchCtrl1=1, switchCtrl2=0, toggle counter=0.
  - The counter counts 0..TOGGLE_HALF-1 and wraps. Both lines invert on the wrap edge.
  - Period is 2·TOGGLE_HALF clocks, duty cycle 50%.
  - Leaving RUN forces both lines to 0 on the same edge.
- cmpValid has no handshake and is evaluated only in RUN. Back-to-back strobes are each counted.
- clearFault and start asserted together in FAULT → IDLE only. The next start must arrive in a later cycle.

## Test plan
- Reset, start pulse, fbRelay=0, fbSwitchOpen=1 during self-test → state=1 for 16 cycles, then state=2. relayCtrl1/2=1/0; switchCtrl1 toggles every 8 clocks with switchCtrl2 its inverse.
- In RUN with good readback (fbRelay=1, fbSwitchOpen=0), apply cmpValid with cmpMatch 0,0,1,0,0 → mismatchCnt 1,2,0,1,2, no fault. A third consecutive mismatch → FAULT, faultCode=2, all controls 0 on the same edge.
- Self-test with fbRelay stuck at 1 → FAULT with faultCode=1 after 16 cycles. start has no effect. clearFault → IDLE, faultCode=0.
- In RUN, hold fbSwitchOpen=1 for 31 cycles, then 0 → no fault. Holding it for 32 cycles → FAULT with faultCode=3.
- Third mismatch and 32nd bad-readback cycle in the same cycle → faultCode=2. Asserting rst mid-RUN → immediate IDLE, all outputs 0, without a clock edge.
